fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 Parameter AW, default 2, pointer width, equal to log2(DEPTH).
REQ-003 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 In_Valid  input  1  fetch stage presents an entry this cycle.
REQ-006 In_Addr  input  32  PC of the fetched instruction.
REQ-007 In_Instruction  input  32  instruction word read at In_Addr.
REQ-008 In_Ready  output  1  queue accepts an entry this cycle.
REQ-009 Flush  input  1  redirect from Jump or taken Branch; discard all queued entries.
REQ-010 Out_Valid  output  1  head entry is valid for decode.
REQ-011 Out_Addr  output  32  PC of the head entry.
REQ-012 Out_Instruction  output  32  instruction word of the head entry.
REQ-013 Out_Ready  input  1  decode consumes the head this cycle.
REQ-014 Count  output  AW+1  number of occupied entries, range 0..DEPTH.

Function
REQ-015 A push SHALL occur when In_Valid and In_Ready are both 1 and Flush is 0.
REQ-016 A pop SHALL occur when Out_Valid and Out_Ready are both 1 and Flush is 0.
REQ-017 In_Ready SHALL be 1 exactly when Count is less than DEPTH; no combinational path from Out_Ready.
REQ-018 Out_Valid SHALL be 1 exactly when Count is nonzero; no combinational path from In_Valid.
REQ-019 Out_Addr and Out_Instruction SHALL reflect the entry at the read pointer; the value is don't-care when Out_Valid is 0.
REQ-020 Latency SHALL be one cycle: an entry pushed at edge N is visible at the head after edge N when the queue was empty. There is no same-cycle bypass.
REQ-021 A simultaneous push and pop SHALL leave Count unchanged and advance both pointers.
REQ-022 When full, In_Ready is 0. A pop that cycle SHALL free one entry, but the push is refused until the next cycle.
REQ-023 Write and read pointers SHALL be AW bits wide and wrap from DEPTH-1 to 0.
REQ-024 Count SHALL increment on a push-only cycle, decrement on a pop-only cycle, and otherwise hold.
REQ-025 Flush SHALL set Count, the write pointer and the read pointer to 0 at the next edge, overriding any same-cycle push or pop.
REQ-026 After Flush, Out_Valid SHALL be 0 for at least one cycle.
REQ-027 Entries SHALL be delivered in push order, with no duplication or loss except by Flush.
REQ-028 A held entry SHALL remain stable while Out_Valid is 1 and Out_Ready is 0.

Reset
REQ-029 Reset low SHALL immediately clear Count and both pointers, giving Out_Valid 0 and In_Ready 1.
REQ-030 Storage array contents SHALL NOT require reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries, identical to power-up.
REQ-032 Reset release SHALL be synchronous to Clock from the environment; the first push is accepted at the first edge after release.

Structure
REQ-033 The shared package SHALL hold the default DEPTH, the 32-bit word width constant, and the entry record type {addr, instruction}.
REQ-034 One sub-module, fq_ptr, SHALL implement the wrapping AW-bit pointer with increment and clear inputs, instantiated twice.
REQ-035 The storage SHALL be a register array indexed by the pointers; no vendor RAM primitive is used.

Verification
REQ-036 Reset low, then idle for 3 cycles -> Out_Valid 0, In_Ready 1, Count 0.
REQ-037 Push PCs 0x00,0x04,0x08,0x0C with Out_Ready 0 -> Count 4, In_Ready 0; a fifth push of 0x10 is refused; then Out_Ready 1 -> outputs 0x00,0x04,0x08,0x0C in order.
REQ-038 With Count 2, assert push 0x20 and pop simultaneously for 5 cycles -> Count stays 2 and the order is preserved across pointer wrap.
REQ-039 With Count 3, assert Flush together with push 0x40 -> next cycle Count 0 and Out_Valid 0; 0x40 never appears at the output.
REQ-040 Assert Reset low asynchronously mid-cycle with Count 3 -> Out_Valid falls before the next edge; after release, push 0x80 -> Out_Addr 0x80 one cycle later.
REQ-041 Apply random In_Valid/Out_Ready over 1000 cycles against a reference queue model -> no mismatch, and Count never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the instruction fetch queue: the default queue depth,
// the word width used for both PC and instruction, and the entry record that
// is stored per queue slot.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int FQ_DEFAULT_DEPTH = 4;
    localparam int FQ_WORD_W        = 32;

    typedef struct packed {
        logic [FQ_WORD_W-1:0] addr;
        logic [FQ_WORD_W-1:0] instruction;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundle of the fetch-side push port, the decode-side pop port, the flush
// redirect and the occupancy count.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge where
// valid and ready are both 1 and flush is 0. The producer must hold valid and
// its payload stable until it is accepted; ready never depends combinationally
// on the partner's valid (in_ready depends only on count, out_valid only on
// count).
//
// Modports:
//   master : fetch/decode environment (drives in_*, flush, out_ready)
//   slave  : the queue (drives in_ready, out_*, count)
// -----------------------------------------------------------------------------
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int AW = 2
);

    logic                 in_valid;
    logic [FQ_WORD_W-1:0] in_addr;
    logic [FQ_WORD_W-1:0] in_instruction;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic [FQ_WORD_W-1:0] out_addr;
    logic [FQ_WORD_W-1:0] out_instruction;
    logic                 out_ready;
    logic [AW:0]          count;

    modport master (
        output in_valid, in_addr, in_instruction, flush, out_ready,
        input  in_ready, out_valid, out_addr, out_instruction, count
    );

    modport slave (
        input  in_valid, in_addr, in_instruction, flush, out_ready,
        output in_ready, out_valid, out_addr, out_instruction, count
    );

endinterface

// File: rtl/fq_ptr.sv
// -----------------------------------------------------------------------------
// fq_ptr
// Wrapping AW-bit queue pointer. Wrap from DEPTH-1 to 0 falls out of the
// natural AW-bit overflow because DEPTH == 2**AW.
//
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (pointer -> 0)
//   inc_i  : advance pointer by one
//   clr_i  : return pointer to 0; wins over inc_i
//   ptr_o  : current pointer value
// -----------------------------------------------------------------------------
module fq_ptr #(
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO between the fetch stage and decode. Holds {PC, instruction}
// records, delivers them in push order, and can be emptied in one cycle by a
// flush from a jump or taken branch.
//
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset; clears count and pointers
//   bus    : fetch_queue_if.slave (push port, pop port, flush, count)
//
// Behaviour notes:
//   - in_ready is derived from count only, so a pop in the same cycle as a
//     full queue does not let a push in; the freed slot is usable next cycle.
//   - No bypass: a pushed entry reaches the head one cycle after its push.
//   - Storage is not reset; only count and pointers define what is valid.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fetch_queue_if.slave      bus
);

    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);

    logic          in_ready_w;
    logic          out_valid_w;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    fq_entry_t     mem_q [DEPTH];
    fq_entry_t     head;

    assign in_ready_w  = (count_q < COUNT_FULL);
    assign out_valid_w = (count_q != '0);

    // Flush suppresses both handshakes so neither pointer nor storage moves.
    assign push = bus.in_valid  & in_ready_w  & ~bus.flush;
    assign pop  = bus.out_ready & out_valid_w & ~bus.flush;

    always_comb begin
        count_d = count_q;
        if (bus.flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    fq_ptr #(.AW(AW)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (push),
        .clr_i  (bus.flush),
        .ptr_o  (wr_ptr)
    );

    fq_ptr #(.AW(AW)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (pop),
        .clr_i  (bus.flush),
        .ptr_o  (rd_ptr)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr] <= '{addr: bus.in_addr, instruction: bus.in_instruction};
        end
    end

    assign head = mem_q[rd_ptr];

    assign bus.in_ready        = in_ready_w;
    assign bus.out_valid       = out_valid_w;
    assign bus.out_addr        = head.addr;
    assign bus.out_instruction = head.instruction;
    assign bus.count           = count_q;

endmodule
